// File: rtl/onset_enumerator_if.sv
// Minterm stream between the enumerator and its consumer.
// Handshake: a beat transfers on a rising clk edge where m_valid && m_ready are
// both high; once m_valid is raised, m_valid and m_data hold until that transfer.
interface onset_enumerator_if #(
  parameter int N_IN = 16
);
  logic            m_valid;
  logic            m_ready;
  logic [N_IN-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/onset_enumerator.sv
// Sweeps every input vector of an attached single-output function and streams the
// minterms whose output matches the selected polarity, in ascending order.
module onset_enumerator #(
  parameter int N_IN     = 16,
  parameter int FUNC_LAT = 0,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pol,
  output logic [N_IN-1:0]     x_o,
  input  logic                y_i,
  onset_enumerator_if.master  m,
  output logic                busy,
  output logic                done,
  output logic [N_IN:0]       match_count,
  output logic [1:0]          state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;
  localparam logic [N_IN-1:0] LAST   = '1;
  localparam logic [N_IN:0]   MC_MAX = {1'b1, {N_IN{1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t          state;
  logic [N_IN-1:0] cnt;
  logic            pol_q;
  logic [N_IN-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   inflight;
  logic            tag_out_v;
  logic [N_IN-1:0] tag_out_x;
  logic            credit, issue, push, pop;

  assign x_o       = cnt;
  assign state_dbg = state;
  assign m.m_valid = (fifo_count != '0);
  assign m.m_data  = mem[rd_ptr];

  // Every slot either already in the FIFO or still travelling through the
  // function is reserved, so a push can never find the FIFO full.
  assign credit = (fifo_count + inflight) < CW'(DEPTH);
  assign issue  = (state == SWEEP) && credit;
  assign push   = tag_out_v && (y_i == pol_q);
  assign pop    = m.m_valid && m.m_ready;

  generate
    if (FUNC_LAT == 0) begin : g_comb
      assign tag_out_v = issue;
      assign tag_out_x = cnt;
      assign inflight  = '0;
    end else begin : g_pipe
      logic            pv [FUNC_LAT];
      logic [N_IN-1:0] px [FUNC_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < FUNC_LAT; i++) begin
            pv[i] <= 1'b0;
            px[i] <= '0;
          end
        end else begin
          pv[0] <= issue;
          px[0] <= cnt;
          for (int i = 1; i < FUNC_LAT; i++) begin
            pv[i] <= pv[i-1];
            px[i] <= px[i-1];
          end
        end
      end

      always_comb begin
        inflight = '0;
        for (int i = 0; i < FUNC_LAT; i++) inflight = inflight + CW'(pv[i]);
      end

      assign tag_out_v = pv[FUNC_LAT-1];
      assign tag_out_x = px[FUNC_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pol_q       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      match_count <= '0;
    end else begin
      if (push && match_count != MC_MAX) match_count <= match_count + (N_IN+1)'(1);
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pol_q       <= pol;
            cnt         <= '0;
            match_count <= '0;
            busy        <= 1'b1;
            state       <= SWEEP;
          end
        end
        SWEEP: begin
          // The last vector leaves the counter parked at all-ones.
          if (issue) begin
            if (cnt == LAST) state <= DRAIN;
            else             cnt   <= cnt + N_IN'(1);
          end
        end
        DRAIN: begin
          if (inflight == '0 && fifo_count == '0) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= tag_out_x;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_onset_enumerator.sv
// Directed bench for onset_enumerator: three instances cover the 4-input
// combinational, 4-input latency-2 and 16-input configurations.
module tb_onset_enumerator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int n;

  // ---------------- DUT A: N_IN=4, FUNC_LAT=0 ----------------
  onset_enumerator_if #(.N_IN(4)) sa ();
  logic       start_a = 1'b0, pol_a = 1'b1, y_a, busy_a, done_a;
  logic [3:0] x_a;
  logic [4:0] mc_a;
  logic [1:0] st_a;
  int         mode_a = 0;
  always_comb y_a = (mode_a == 0) ? 1'b1 : (x_a[0] & x_a[1]);

  onset_enumerator #(.N_IN(4), .FUNC_LAT(0), .DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pol(pol_a), .x_o(x_a), .y_i(y_a),
    .m(sa.master), .busy(busy_a), .done(done_a), .match_count(mc_a), .state_dbg(st_a)
  );

  // ---------------- DUT B: N_IN=4, FUNC_LAT=2 ----------------
  onset_enumerator_if #(.N_IN(4)) sb ();
  logic       start_b = 1'b0, pol_b = 1'b1, busy_b, done_b;
  logic [3:0] x_b;
  logic [4:0] mc_b;
  logic [1:0] st_b;
  logic       r1_b = 1'b0, r2_b = 1'b0;
  always @(posedge clk) begin
    r1_b <= x_b[3] & ~x_b[0];
    r2_b <= r1_b;
  end

  onset_enumerator #(.N_IN(4), .FUNC_LAT(2), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pol(pol_b), .x_o(x_b), .y_i(r2_b),
    .m(sb.master), .busy(busy_b), .done(done_b), .match_count(mc_b), .state_dbg(st_b)
  );

  // ---------------- DUT C: N_IN=16, FUNC_LAT=0 ----------------
  onset_enumerator_if #(.N_IN(16)) sc ();
  logic        start_c = 1'b0, pol_c = 1'b1, y_c = 1'b0, busy_c, done_c;
  logic [15:0] x_c;
  logic [16:0] mc_c;
  logic [1:0]  st_c;

  onset_enumerator #(.N_IN(16), .FUNC_LAT(0), .DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .pol(pol_c), .x_o(x_c), .y_i(y_c),
    .m(sc.master), .busy(busy_c), .done(done_c), .match_count(mc_c), .state_dbg(st_c)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [3:0] exp_qa[$];
  logic [3:0] exp_qb[$];
  int first_a = 0, last_a = 0, pops_a = 0, dn_a = 0, valid_c = 0;

  always @(negedge clk) begin
    if (rst_n && sa.m_valid && sa.m_ready) begin
      checks++;
      assert (exp_qa.size() != 0) else begin
        errors++;
        $error("FAIL a_extra_pop: observed %0h expected none", sa.m_data);
      end
      if (exp_qa.size() != 0) chk("a_data", 32'(sa.m_data), 32'(exp_qa.pop_front()));
      if (pops_a == 0) first_a = cyc;
      last_a = cyc;
      pops_a++;
    end
    if (done_a) dn_a++;
  end

  always @(negedge clk) begin
    if (rst_n && sb.m_valid && sb.m_ready) begin
      checks++;
      assert (exp_qb.size() != 0) else begin
        errors++;
        $error("FAIL b_extra_pop: observed %0h expected none", sb.m_data);
      end
      if (exp_qb.size() != 0) chk("b_data", 32'(sb.m_data), 32'(exp_qb.pop_front()));
    end
    if (sc.m_valid) valid_c++;
  end

  // ---------------- driver tasks ----------------
  task automatic start_a_t(input logic p);
    @(negedge clk);
    pol_a = p; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; pol_a = ~p;
    pops_a = 0; dn_a = 0;
  endtask

  task automatic wait_done_a(input int lim, output int cnt);
    cnt = 0;
    while (!done_a && cnt < lim) begin @(negedge clk); cnt++; end
    chk("a_done_timeout", 32'(cnt < lim), 1);
  endtask

  task automatic load_a(input logic [3:0] vals[$]);
    exp_qa = vals;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    sa.m_ready = 1'b1; sb.m_ready = 1'b1; sc.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 32'(x_a), 0);
    chk("rst_valid", 32'(sa.m_valid), 0);
    chk("rst_data", 32'(sa.m_data), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_mc", 32'(mc_a), 0);
    chk("rst_state", 32'(st_a), 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: full on-set, back-to-back stream
    mode_a = 0;
    load_a('{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15});
    start_a_t(1'b1);
    chk("t1_busy", 32'(busy_a), 1);
    wait_done_a(200, n);
    chk("t1_done_lat", n, 18);
    chk("t1_busy_at_done", 32'(busy_a), 0);
    repeat (3) @(negedge clk);
    chk("t1_mc", 32'(mc_a), 16);
    chk("t1_left", exp_qa.size(), 0);
    chk("t1_pops", pops_a, 16);
    chk("t1_consecutive", last_a - first_a, 15);
    chk("t1_done_pulses", dn_a, 1);
    chk("t1_x_hold", 32'(x_a), 15);
    chk("t1_idle", 32'(st_a), 0);

    // 2: off-set of x0&x1
    mode_a = 1;
    load_a('{0,1,2,4,5,6,8,9,10,12,13,14});
    start_a_t(1'b0);
    wait_done_a(200, n);
    repeat (2) @(negedge clk);
    chk("t2_mc", 32'(mc_a), 12);
    chk("t2_left", exp_qa.size(), 0);
    chk("t2_done_pulses", dn_a, 1);

    // 3: consumer stall fills the FIFO and freezes the sweep
    mode_a = 0;
    sa.m_ready = 1'b0;
    load_a('{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15});
    start_a_t(1'b1);
    repeat (5) @(negedge clk);
    chk("t3_valid_early", 32'(sa.m_valid), 1);
    chk("t3_data_early", 32'(sa.m_data), 0);
    repeat (14) @(negedge clk);
    chk("t3_valid", 32'(sa.m_valid), 1);
    chk("t3_data", 32'(sa.m_data), 0);
    chk("t3_x_stall", 32'(x_a), 4);
    chk("t3_state", 32'(st_a), 1);
    start_a = 1'b1; pol_a = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
    chk("t3_start_ignored", 32'(x_a), 4);
    chk("t3_busy", 32'(busy_a), 1);
    sa.m_ready = 1'b1;
    wait_done_a(200, n);
    repeat (2) @(negedge clk);
    chk("t3_mc", 32'(mc_a), 16);
    chk("t3_left", exp_qa.size(), 0);
    chk("t3_pops", pops_a, 16);

    // 4: latency-2 function y = x3 & ~x0
    exp_qb = '{8, 10, 12, 14};
    @(negedge clk);
    pol_b = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; pol_b = 1'b0;
    n = 0;
    while (!done_b && n < 200) begin @(negedge clk); n++; end
    chk("t4_done_timeout", 32'(n < 200), 1);
    repeat (2) @(negedge clk);
    chk("t4_mc", 32'(mc_b), 4);
    chk("t4_left", exp_qb.size(), 0);

    // 6: asynchronous reset in the middle of a sweep
    mode_a = 0;
    load_a('{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15});
    start_a_t(1'b1);
    repeat (7) @(negedge clk);
    chk("t6_x_mid", 32'(x_a), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_x", 32'(x_a), 0);
    chk("t6_rst_valid", 32'(sa.m_valid), 0);
    chk("t6_rst_data", 32'(sa.m_data), 0);
    chk("t6_rst_busy", 32'(busy_a), 0);
    chk("t6_rst_mc", 32'(mc_a), 0);
    chk("t6_rst_state", 32'(st_a), 0);
    exp_qa.delete();
    @(negedge clk) rst_n = 1'b1;
    load_a('{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15});
    start_a_t(1'b1);
    wait_done_a(200, n);
    chk("t6_done_lat", n, 18);
    repeat (2) @(negedge clk);
    chk("t6_mc", 32'(mc_a), 16);
    chk("t6_left", exp_qa.size(), 0);

    // 5: 16-input sweep with an empty on-set
    valid_c = 0;
    @(negedge clk);
    pol_c = 1'b1; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0; pol_c = 1'b0;
    n = 0;
    while (!done_c && n < 70000) begin @(negedge clk); n++; end
    chk("t5_done_lat", n, 65537);
    repeat (2) @(negedge clk);
    chk("t5_mc", 32'(mc_c), 0);
    chk("t5_no_valid", valid_c, 0);
    chk("t5_x_hold", 32'(x_c), 32'hFFFF);
    chk("t5_idle", 32'(busy_c), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
